seq_cpu_core: RTL and testbench
===============================

Name: seq_cpu_core

Overview:
- Parametrised multi-cycle sequenced processor core; successor to the board-level single-step datapath.
- Generalises data width, register count and program depth.
- Adds a proper fetch/execute/writeback FSM, free-run mode, conditional jumps, ALU flags and a halt state.
- Sits between an external combinational program ROM, the switch inputs and the 7-seg/LED display logic.
- Step pulses come from the existing clock_pulse debouncer, driven into `step`.

Parameters:
- DATA_W, 8: datapath and register width, 4..16.
- NREG, 4: number of general registers; power of 2, 2..16. Register fields use the low log2(NREG) bits.
- PROG_DEPTH, 256: program words; power of 2, ≤256. The PC is log2(PROG_DEPTH) bits.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- step  in  1  one-cycle pulse; executes one instruction when idle.
- run  in  1  level; while high, instructions execute back-to-back.
- sw_a  in  DATA_W  external operand A (switches).
- sw_b  in  DATA_W  external operand B (switches).
- imem_addr  out  log2(PROG_DEPTH)  program address, equal to the PC.
- imem_data  in  16  instruction word; combinational ROM, valid in the same cycle.
- out_reg  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out_reg is written.
- pc  out  log2(PROG_DEPTH)  current PC.
- ir  out  16  latched instruction.
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- halted  out  1  high in HALT state.
- busy  out  1  high in FETCH, EXEC or WB.

Behaviour:
- Instruction format: op = [15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0], imm8 = [7:0].
- Reset (synchronous, any state, including mid-instruction):
  - State → IDLE.
  - pc, ir, all registers, out_reg, carry and zero → 0.
  - out_valid, halted and busy → 0.
  - No write in that cycle completes.
- FSM states: IDLE, FETCH, EXEC, WB, HALT.
  - IDLE → FETCH when step or run is high.
  - FETCH: ir ← imem_data; → EXEC.
  - EXEC: compute the result and next PC into internal registers; → WB.
  - WB: commit rd / out_reg / flags / pc. Then:
    - → HALT if op = F.
    - else → FETCH if run is high.
    - else → IDLE.
  - HALT: hold; only reset leaves it.
- Latency: 3 cycles per instruction.
  - A step accepted in cycle N commits in cycle N+3.
  - Free-run throughput is one instruction per 3 cycles.
- Step handling:
  - Steps arriving while busy or halted are ignored, not queued.
  - step and run high together behave as run.
  - Dropping run mid-instruction finishes the current instruction, then goes to IDLE.
- Ops; results are truncated to DATA_W:
  - 0 ADD: rd = rs1 + rs2; carry = carry-out.
  - 1 SUB: rd = rs1 − rs2; carry = borrow (rs1 < rs2).
  - 2 MUL: rd = low DATA_W bits of the product; carry = 1 if any high product bit is nonzero.
  - 3 DIV: rd = rs1 / rs2, unsigned. Divide by 0 gives rd = all-ones and carry = 1.
  - 4 SHL: rd = rs1 << 1; carry = old MSB.
  - 5 SHR: rd = rs1 >> 1, logical; carry = old LSB.
  - 6 AND, 7 OR, 8 XOR: carry = 0.
  - 9 LDA: rd = sw_a. A LDB: rd = sw_b. Both sampled in EXEC.
  - B OUT: out_reg = R[rs1]; out_valid pulses in WB.
  - C LDI: rd = imm8, zero-extended or truncated to DATA_W.
  - D JZ: if zero = 1, pc = imm8 mod PROG_DEPTH; else pc + 1.
  - E JMP: pc = imm8 mod PROG_DEPTH.
  - F HALT: pc unchanged.
- Flags:
  - zero = (result == 0); carry as listed above.
  - Both flags are updated only by ops 0–8; all other ops leave them unchanged.
- PC:
  - Increments by 1 in WB for all non-jump, non-halt ops.
  - Wraps from PROG_DEPTH−1 to 0.
- Register reads use values from before this instruction's commit, so rd = rs1 = rs2 is legal (e.g. ADD R1,R1,R1 doubles R1).
- out_valid is high for exactly one cycle per OUT; it is 0 at all other times.

Test Plan:
- Reset/step: assert reset, pulse step, ROM[0] = C105 (LDI R1,0x05). Required: after 3 cycles R1 = 0x05, pc = 1, busy low. A second step during busy does not advance pc further.
- ADD with carry and zero: R1 = 0xF0, R2 = 0x10, execute 0312 (ADD R3,R1,R2). Required: R3 = 0x00, carry = 1, zero = 1. Then OUT R3 (B030) → out_reg = 0x00, out_valid high 1 cycle.
- Divide by zero and MUL overflow:
  - R1 = 0x07, R0 = 0, execute 3210 (DIV R2,R1,R0) → R2 = 0xFF, carry = 1.
  - R1 = 0x20, R2 = 0x10, MUL → 0x00, carry = 1.
- Free-run loop: run = 1 with program LDA R1; SUB R1,R1,R2 (R2 = 1); JZ 0x05; JMP 0x01; …; HALT at 0x05; sw_a = 3.
  - Required: halted asserts after the loop executes 3 times.
  - Cycle count from start to halted = 3 × (instructions executed).
  - Subsequent step/run are ignored.
- PC wrap: PROG_DEPTH = 16, ROM all 0x0000 (ADD R0,R0,R0), run for 16 instructions → pc returns to 0. JMP 0x13 → pc = 3.
- Reset mid-instruction: assert reset in the EXEC cycle of LDI R1,0xAA → R1 = 0, pc = 0, state IDLE next cycle; no out_valid.

Source files
------------

// File: rtl/seq_cpu_core.sv
// Multi-cycle sequenced processor core: FETCH/EXEC/WB per instruction, single-step
// or free-run, with ALU carry/zero flags, conditional jumps and a sticky HALT.
module seq_cpu_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NREG       = 4,
  parameter int unsigned PROG_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step,
  input  logic                          run,
  input  logic [DATA_W-1:0]             sw_a,
  input  logic [DATA_W-1:0]             sw_b,
  output logic [$clog2(PROG_DEPTH)-1:0] imem_addr,
  input  logic [15:0]                   imem_data,
  output logic [DATA_W-1:0]             out_reg,
  output logic                          out_valid,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [15:0]                   ir,
  output logic                          carry,
  output logic                          zero,
  output logic                          halted,
  output logic                          busy
);

  localparam int unsigned PW    = $clog2(PROG_DEPTH);
  localparam int unsigned RW    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned PRODW = 2 * DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREG];

  logic [DATA_W-1:0] res_q;
  logic [PW-1:0]     npc_q;
  logic              carry_q, zero_q, wr_q, flags_q;

  logic [3:0]        op;
  logic [RW-1:0]     rd_i, rs1_i, rs2_i;
  logic [DATA_W-1:0] opa, opb, res_c;
  logic [DATA_W:0]   sum_c;
  logic [PRODW-1:0]  prod_c;
  logic [PW-1:0]     npc_c, jmp_c;
  logic              carry_c, zero_c, wr_c, flags_c;

  assign imem_addr = pc;
  assign op        = ir[15:12];
  assign rd_i      = ir[8 +: RW];
  assign rs1_i     = ir[4 +: RW];
  assign rs2_i     = ir[0 +: RW];

  // ALU, flag and next-PC evaluation from the latched instruction
  always_comb begin
    opa     = regs[rs1_i];
    opb     = regs[rs2_i];
    sum_c   = {1'b0, opa} + {1'b0, opb};
    prod_c  = PRODW'(opa) * PRODW'(opb);
    jmp_c   = PW'(ir[7:0]);
    res_c   = '0;
    carry_c = carry;
    wr_c    = 1'b0;
    flags_c = 1'b0;
    npc_c   = pc + PW'(1);
    case (op)
      4'h0: begin res_c = sum_c[DATA_W-1:0]; carry_c = sum_c[DATA_W]; wr_c = 1'b1; flags_c = 1'b1; end
      4'h1: begin res_c = opa - opb; carry_c = (opa < opb); wr_c = 1'b1; flags_c = 1'b1; end
      4'h2: begin res_c = prod_c[DATA_W-1:0]; carry_c = |prod_c[PRODW-1:DATA_W]; wr_c = 1'b1; flags_c = 1'b1; end
      4'h3: begin
        wr_c    = 1'b1;
        flags_c = 1'b1;
        if (opb == '0) begin
          res_c   = '1;
          carry_c = 1'b1;
        end else begin
          res_c   = opa / opb;
          carry_c = 1'b0;
        end
      end
      4'h4: begin res_c = {opa[DATA_W-2:0], 1'b0}; carry_c = opa[DATA_W-1]; wr_c = 1'b1; flags_c = 1'b1; end
      4'h5: begin res_c = {1'b0, opa[DATA_W-1:1]}; carry_c = opa[0]; wr_c = 1'b1; flags_c = 1'b1; end
      4'h6: begin res_c = opa & opb; carry_c = 1'b0; wr_c = 1'b1; flags_c = 1'b1; end
      4'h7: begin res_c = opa | opb; carry_c = 1'b0; wr_c = 1'b1; flags_c = 1'b1; end
      4'h8: begin res_c = opa ^ opb; carry_c = 1'b0; wr_c = 1'b1; flags_c = 1'b1; end
      4'h9: begin res_c = sw_a; wr_c = 1'b1; end
      4'hA: begin res_c = sw_b; wr_c = 1'b1; end
      4'hB: res_c = opa;
      4'hC: begin res_c = DATA_W'(ir[7:0]); wr_c = 1'b1; end
      4'hD: if (zero) npc_c = jmp_c;
      4'hE: npc_c = jmp_c;
      default: npc_c = pc;
    endcase
    zero_c = (res_c == '0);
  end

  // Sequencer; reset wins over any in-flight commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      halted    <= 1'b0;
      busy      <= 1'b0;
      res_q     <= '0;
      npc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      wr_q      <= 1'b0;
      flags_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step || run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= imem_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= res_c;
          npc_q   <= npc_c;
          carry_q <= carry_c;
          zero_q  <= zero_c;
          wr_q    <= wr_c;
          flags_q <= flags_c;
          state   <= S_WB;
        end
        S_WB: begin
          if (wr_q) regs[rd_i] <= res_q;
          if (flags_q) begin
            carry <= carry_q;
            zero  <= zero_q;
          end
          if (op == 4'hB) begin
            out_reg   <= res_q;
            out_valid <= 1'b1;
          end
          pc <= npc_q;
          if (op == 4'hF) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (run) begin
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cpu_core.sv
// Scoreboard bench for seq_cpu_core: an instruction-level interpreter predicts each
// step's architectural state and every OUT value; a monitor checks out_valid pulses.
module tb_seq_cpu_core;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned PD = 16;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          step = 1'b0;
  logic          run = 1'b0;
  logic [DW-1:0] sw_a = '0;
  logic [DW-1:0] sw_b = '0;
  logic [PW-1:0] imem_addr, pc;
  logic [15:0]   imem_data, ir;
  logic [DW-1:0] out_reg;
  logic          out_valid, carry, zero, halted, busy;

  logic [15:0]   rom [PD];

  assign imem_data = rom[imem_addr];

  seq_cpu_core #(.DATA_W(DW), .NREG(NR), .PROG_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .step(step), .run(run),
    .sw_a(sw_a), .sw_b(sw_b), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_reg(out_reg), .out_valid(out_valid), .pc(pc), .ir(ir),
    .carry(carry), .zero(zero), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Architectural reference state
  int m_r [NR];
  int m_pc;
  bit m_c, m_z, m_h;
  int exp_out [$];
  int mon_e;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every out_valid pulse must match the next predicted OUT
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      total++;
      if (exp_out.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got out_reg=%0d expected no pulse", out_reg);
      end else begin
        mon_e = exp_out.pop_front();
        if (int'(out_reg) != mon_e) begin
          bad++;
          $display("FAIL out_value: got %0d expected %0d", out_reg, mon_e);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_r[i] = 0;
    m_pc = 0; m_c = 0; m_z = 0; m_h = 0;
  endtask

  // One instruction at ISA level using plain integer arithmetic
  task automatic model_exec();
    int w, op, rd, a, b, imm, res, p;
    w   = int'(rom[m_pc]);
    op  = (w >> 12) & 15;
    rd  = (w >> 8) & (NR - 1);
    a   = m_r[(w >> 4) & (NR - 1)];
    b   = m_r[w & (NR - 1)];
    imm = w & 255;
    res = 0;
    p   = (m_pc + 1) % PD;
    case (op)
      0: begin res = (a + b) % 256; m_c = (a + b) > 255; end
      1: begin res = (a - b + 256) % 256; m_c = (a < b); end
      2: begin res = (a * b) % 256; m_c = (a * b) > 255; end
      3: if (b == 0) begin res = 255; m_c = 1; end else begin res = a / b; m_c = 0; end
      4: begin res = (a * 2) % 256; m_c = (a >= 128); end
      5: begin res = a / 2; m_c = a % 2; end
      6: begin res = a & b; m_c = 0; end
      7: begin res = a | b; m_c = 0; end
      8: begin res = a ^ b; m_c = 0; end
      9: res = int'(sw_a);
      10: res = int'(sw_b);
      11: exp_out.push_back(a);
      12: res = imm % 256;
      13: if (m_z) p = imm % PD;
      14: p = imm % PD;
      default: begin p = m_pc; m_h = 1; end
    endcase
    if (op <= 8) m_z = (res == 0);
    if (op <= 10 || op == 12) m_r[rd] = res;
    m_pc = p;
  endtask

  task automatic apply_reset();
    reset = 1'b1; step = 1'b0; run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic rom_fill(input logic [15:0] w);
    for (int i = 0; i < PD; i++) rom[i] = w;
  endtask

  // Single step; optionally pulses step again mid-instruction (must be ignored)
  task automatic do_step(input bit extra);
    int n;
    int word;
    word = int'(rom[m_pc]);
    model_exec();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n = 1;
    while (busy && n < 20) begin
      step = (extra && n == 2);
      @(negedge clk);
      n++;
    end
    step = 1'b0;
    chk("latency", n, 4);
    chk("ir", int'(ir), word);
    chk("pc", int'(pc), m_pc);
    chk("carry", int'(carry), int'(m_c));
    chk("zero", int'(zero), int'(m_z));
    chk("halted", int'(halted), int'(m_h));
    if (extra) begin
      @(negedge clk);
      chk("step_not_queued_busy", int'(busy), 0);
      chk("step_not_queued_pc", int'(pc), m_pc);
    end
  endtask

  // Free-run until HALT; returns the number of instructions executed
  task automatic run_to_halt(output int k);
    int n;
    k = 0;
    while (!m_h && k < 200) begin
      model_exec();
      k++;
    end
    run = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n = 1;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    chk("run_cycles", n - 1, 3 * k);
    chk("run_halted", int'(halted), 1);
    chk("run_busy", int'(busy), 0);
    chk("run_pc", int'(pc), m_pc);
    chk("run_carry", int'(carry), int'(m_c));
    chk("run_zero", int'(zero), int'(m_z));
  endtask

  initial begin
    int k;
    rom_fill(16'h0000);
    apply_reset();

    chk("rst_pc", int'(pc), 0);
    chk("rst_ir", int'(ir), 0);
    chk("rst_out_reg", int'(out_reg), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_flags", int'({carry, zero}), 0);
    chk("rst_halted_busy", int'({halted, busy}), 0);

    // LDI then OUT, with an ignored step while busy
    rom[0] = 16'hC105; rom[1] = 16'hB010;
    do_step(1'b1);
    chk("ldi_pc", int'(pc), 1);
    do_step(1'b0);

    // ADD overflow to zero, then OUT R3
    apply_reset();
    rom[0] = 16'hC1F0; rom[1] = 16'hC210; rom[2] = 16'h0312; rom[3] = 16'hB030;
    for (int i = 0; i < 3; i++) do_step(1'b0);
    chk("add_carry", int'(carry), 1);
    chk("add_zero", int'(zero), 1);
    do_step(1'b0);

    // Divide by zero and MUL overflow
    apply_reset();
    rom[0] = 16'hC107; rom[1] = 16'hC000; rom[2] = 16'h3210; rom[3] = 16'hB020;
    rom[4] = 16'hC120; rom[5] = 16'hC210; rom[6] = 16'h2312; rom[7] = 16'hB030;
    for (int i = 0; i < 3; i++) do_step(1'b0);
    chk("div0_carry", int'(carry), 1);
    do_step(1'b0);
    for (int i = 0; i < 3; i++) do_step(1'b0);
    chk("mul_carry", int'(carry), 1);
    chk("mul_zero", int'(zero), 1);
    do_step(1'b0);

    // Free-run countdown loop to HALT
    apply_reset();
    rom_fill(16'h0000);
    rom[0] = 16'hC201; rom[1] = 16'h9100; rom[2] = 16'h1112; rom[3] = 16'hD006;
    rom[4] = 16'hE002; rom[6] = 16'hF000;
    sw_a = 8'd3;
    run_to_halt(k);
    chk("loop_instr_count", k, 11);
    chk("loop_halt_pc", int'(pc), 6);
    step = 1'b1; run = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0; run = 1'b0;
    chk("halt_sticky", int'(halted), 1);
    chk("halt_no_busy", int'(busy), 0);
    chk("halt_pc_hold", int'(pc), 6);

    // PC wrap and jump target modulo depth
    apply_reset();
    rom_fill(16'h0000);
    for (int i = 0; i < 16; i++) do_step(1'b0);
    chk("wrap_pc", int'(pc), 0);
    rom[0] = 16'hE013;
    do_step(1'b0);
    chk("jmp_mod_pc", int'(pc), 3);

    // Reset during EXEC of LDI R1,0xAA: nothing commits
    apply_reset();
    rom_fill(16'h0000);
    rom[0] = 16'hC1AA;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pc", int'(pc), 0);
    @(negedge clk);
    chk("midrst_idle", int'(busy), 0);
    rom[0] = 16'hB010;
    do_step(1'b0);

    // Randomised programs without HALT, single-stepped
    for (int t = 0; t < 3; t++) begin
      apply_reset();
      for (int i = 0; i < PD; i++)
        rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      for (int s = 0; s < 40; s++) begin
        sw_a = 8'($urandom);
        sw_b = 8'($urandom);
        do_step(1'($urandom_range(0, 3) == 0));
      end
    end

    // Randomised program ending in HALT, free-run
    apply_reset();
    for (int i = 0; i < PD; i++)
      rom[i] = {4'($urandom_range(0, 12)), 12'($urandom)};
    rom[PD-1] = 16'hF000;
    for (int i = 0; i < PD - 1; i++)
      if (rom[i][15:12] == 4'hB) rom[i] = 16'hC000 | {8'h0, rom[i][7:0]};
    rom[7] = 16'hB010;
    sw_a = 8'($urandom);
    sw_b = 8'($urandom);
    run_to_halt(k);

    @(negedge clk);
    #1;
    chk("out_queue_drained", exp_out.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
